mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer for the EX stage, beside the single-cycle ALU.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  - Iterates one bit per cycle; owns the HI/LO registers.
//  - Drives a stall request that holds IF/ID/EX while an operation runs.
// PARAMETERS
//  WIDTH   32  operand width; HI/LO width; iteration count per mul/div
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      op valid in EX this cycle
//  op         in   3      000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
//  srcA       in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//  srcB       in   WIDTH  multiplier / divisor
//  flush      in   1      abort in-flight op (branch/exception flush)
//  busy       out  1      state != IDLE
//  stall      out  1      = busy; pipeline must hold EX while high
//  done       out  1      one-cycle pulse: HI/LO written this edge
//  hi         out  WIDTH  HI register
//  lo         out  WIDTH  LO register
// BEHAVIOUR
//  - Reset (synchronous, rst=1 at edge): state=IDLE; hi=lo=0; busy=stall=done=0; counter=0.
//    Reset overrides all other inputs, including an in-flight op.
//  - FSM states: IDLE, CALC, FIX.
//  - IDLE, start=1, op in {001..100} at edge t:
//    - Latch operand magnitudes (signed ops: two's-complement abs), both sign bits, and op.
//    - Counter=0; go to CALC.
//  - IDLE, start=1, op=101 (MTHI) or 110 (MTLO):
//    - hi (or lo) <= srcA at next edge; stays IDLE; done not pulsed.
//  - IDLE, op=000 or start=0: no change.
//  - Undefined op codes 111 are treated as NOP.
//  - CALC: runs WIDTH cycles, one bit per cycle.
//    - Multiply: shift-add over a 2*WIDTH accumulator.
//    - Divide: restoring division, 2*WIDTH remainder/quotient register.
//    - After the WIDTH-th iteration, go to FIX.
//  - FIX (one cycle): apply signs, then write hi/lo; done=1; return to IDLE.
//    - MULT: negate 2*WIDTH product if signA^signB.
//    - DIV: quotient negated if signA^signB; remainder carries dividend's sign.
//    - MULTU/DIVU: no correction.
//    - Mul: hi=product[2W-1:W], lo=product[W-1:0]. Div: lo=quotient, hi=remainder.
//  - Latency: start accepted at edge t; hi/lo valid and done=1 after edge t+WIDTH+1.
//    busy=1 for exactly WIDTH+1 cycles.
//  - start while busy is ignored (stalled pipeline re-presents it). MTHI/MTLO while busy are ignored.
//  - Divide by zero (srcB==0, DIV or DIVU): still takes the full latency.
//    Writes lo={WIDTH{1'b1}}, hi=srcA as latched; no sign fix.
//  - DIV -2^(W-1) / -1: lo=0x80000000, hi=0; no overflow flag.
//  - flush=1 while busy: return to IDLE at next edge; hi/lo unchanged; done=0.
//  - flush=1 in IDLE: any start that cycle is dropped, including MTHI/MTLO.
//  - flush and FIX in the same cycle: flush wins; no hi/lo write.
//  - Operands are consumed only at acceptance; srcA/srcB may change during CALC.
// TESTING
//  1. MULTU FFFFFFFF*FFFFFFFF -> after 33 cycles done=1; hi=FFFFFFFE, lo=00000001.
//  2. MULT -3 * 7 -> hi=FFFFFFFF, lo=FFFFFFEB; busy high exactly 33 cycles.
//  3. DIV -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
//  4. DIVU 0x1234 / 0 -> lo=FFFFFFFF, hi=00001234 after 33 cycles.
//  5. MULT started, flush at cycle 10 -> busy=0 next cycle; hi/lo keep prior values; no done.
//     Same with rst at cycle 10 -> hi=lo=0.
//  6. MTHI 0xA5A5A5A5 in IDLE -> hi updated next edge, busy stays 0.
//     MTLO issued during CALC -> lo unchanged.

Source files
------------

// File: rtl/mdu_if.sv
// Purpose : Handshake/data bundle between the EX stage and the multiply/divide sequencer.
// Ports   : master = EX stage (drives start/op/srcA/srcB/flush, reads busy/stall/done/hi/lo);
//           slave  = mdu_ctrl (the reverse direction).
interface mdu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, flush,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, flush,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Purpose : Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MTHI/MTLO write in one edge.
// Latency : op accepted at edge t, HI/LO written and done pulsed after edge t+WIDTH+1.
// Backpressure: stall (= busy) holds the pipeline; starts while busy are ignored, flush aborts.
// Ports   : clk, rst (sync, active-high); bus (mdu_if.slave): start/op/srcA/srcB/flush in,
//           busy/stall/done/hi/lo out.
module mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;   // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   b_q;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]         op_q;
  logic               sign_a_q, sign_b_q, bzero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept, is_muldiv, signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               is_mul_q;
  logic [WIDTH:0]     mul_sum, rem_sh;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept    = bus.start && !bus.flush;
  assign is_muldiv = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign mag_a     = (signed_op && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
  assign mag_b     = (signed_op && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
  assign is_mul_q  = (op_q == OP_MULT) || (op_q == OP_MULTU);

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    acc_step = '0;
    if (is_mul_q) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, b_q}) begin
      acc_step = {rem_sh[WIDTH-1:0] - b_q, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX. A zero divisor leaves quotient all-ones and
  // remainder equal to the dividend magnitude, which is returned unmodified.
  always_comb begin
    prod_fix = acc_q;
    quo_fix  = acc_q[WIDTH-1:0];
    rem_fix  = acc_q[2*WIDTH-1:WIDTH];
    if (op_q == OP_MULT && (sign_a_q ^ sign_b_q)) begin
      prod_fix = -acc_q;
    end
    if (op_q == OP_DIV && !bzero_q) begin
      if (sign_a_q ^ sign_b_q) quo_fix = -acc_q[WIDTH-1:0];
      if (sign_a_q)            rem_fix = -acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_muldiv) state_d = CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.stall = (state_q != IDLE);
    bus.done  = done_q;
    bus.hi    = hi_q;
    bus.lo    = lo_q;
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_muldiv) begin
            op_q     <= bus.op;
            sign_a_q <= signed_op & bus.srcA[WIDTH-1];
            sign_b_q <= signed_op & bus.srcB[WIDTH-1];
            bzero_q  <= (bus.srcB == '0);
            cnt_q    <= '0;
            // Multiplier (srcB) sits in the low half and is shifted out LSB first;
            // the dividend sits there for division and is shifted out MSB first.
            if (bus.op == OP_MULT || bus.op == OP_MULTU) begin
              acc_q <= {{WIDTH{1'b0}}, mag_b};
              b_q   <= mag_a;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, mag_a};
              b_q   <= mag_b;
            end
          end else if (accept && bus.op == OP_MTHI) begin
            hi_q <= bus.srcA;
          end else if (accept && bus.op == OP_MTLO) begin
            lo_q <= bus.srcA;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        FIX: begin
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_mul_q) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: expected HI/LO pushed to a scoreboard at issue,
// popped and compared by a monitor on every done pulse.
module tb_mdu_ctrl;
  localparam int W = 32;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;
  localparam logic [2:0] MTHI  = 3'b101;
  localparam logic [2:0] MTLO  = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) m ();
  mdu_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(m));

  int vectors    = 0;
  int miscompares = 0;
  logic [63:0] sb_q[$];   // {hi, lo}
  int cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (m.done === 1'b1) begin
      logic [63:0] e;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", m.hi, m.lo);
      end else begin
        e = sb_q.pop_front();
        check("done_hi", {32'h0, m.hi}, {32'h0, e[63:32]});
        check("done_lo", {32'h0, m.lo}, {32'h0, e[31:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    cnt++;
  endtask

  // Present one op for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    m.start = 1'b1; m.op = o; m.srcA = a; m.srcB = b;
    @(posedge clk); #1;
    m.start = 1'b0; m.op = NOP; m.srcA = $urandom; m.srcB = $urandom;
    cnt = 0;
  endtask

  task automatic wait_idle();
    while (m.busy === 1'b1 && cnt < 100) step();
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    sb_q.push_back({eh, el});
    issue(o, a, b);
    wait_idle();
    check("busy_cycles", 64'(cnt), 64'd33);
  endtask

  initial begin
    m.start = 1'b0; m.op = NOP; m.srcA = '0; m.srcB = '0; m.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_busy",  {63'h0, m.busy},  64'h0);
    check("rst_stall", {63'h0, m.stall}, 64'h0);
    check("rst_done",  {63'h0, m.done},  64'h0);
    check("rst_hilo",  {m.hi, m.lo},     64'h0);

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(DIVU,  32'd7,        32'd2,        32'h00000001, 32'h00000003);
    run_op(DIVU,  32'h1234,     32'd0,        32'h00001234, 32'hFFFFFFFF);
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op(DIV,   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2);

    // MTHI / MTLO in IDLE
    issue(MTHI, 32'hA5A5A5A5, 32'h0);
    check("mthi_hi",   {32'h0, m.hi}, 64'hA5A5A5A5);
    check("mthi_busy", {63'h0, m.busy}, 64'h0);
    issue(MTLO, 32'h0BADF00D, 32'h0);
    check("mtlo_hilo", {m.hi, m.lo}, 64'hA5A5A5A5_0BADF00D);

    // Flush 10 cycles into a MULT: abort, HI/LO untouched, no done.
    issue(MULT, 32'd5, 32'd5);
    repeat (9) step();
    m.flush = 1'b1;
    step();
    m.flush = 1'b0;
    check("flush_busy", {63'h0, m.busy}, 64'h0);
    check("flush_hilo", {m.hi, m.lo}, 64'hA5A5A5A5_0BADF00D);
    repeat (40) step();

    // Flush in IDLE drops an MTHI presented the same cycle.
    m.flush = 1'b1;
    issue(MTHI, 32'h12345678, 32'h0);
    m.flush = 1'b0;
    check("flush_idle_hi", {32'h0, m.hi}, 64'hA5A5A5A5);

    // MTLO and a second MULT presented mid-CALC are ignored.
    sb_q.push_back({32'h0, 32'h6});
    issue(MULTU, 32'd2, 32'd3);
    repeat (3) step();
    m.start = 1'b1; m.op = MTLO; m.srcA = 32'hDEADDEAD;
    step();
    check("mtlo_busy_lo", {32'h0, m.lo}, 64'h0BADF00D);
    m.op = MULT; m.srcA = 32'hFFFF; m.srcB = 32'hFFFF;
    step();
    m.start = 1'b0; m.op = NOP;
    wait_idle();
    check("busy_cycles_ign", 64'(cnt), 64'd33);

    // Flush landing on the FIX cycle suppresses the write.
    issue(MULTU, 32'd9, 32'd9);
    repeat (W) step();
    m.flush = 1'b1;
    step();
    m.flush = 1'b0;
    check("flush_fix_busy", {63'h0, m.busy}, 64'h0);
    check("flush_fix_hilo", {m.hi, m.lo}, 64'h00000000_00000006);
    repeat (5) step();

    // Reset 10 cycles into an op clears everything.
    issue(MULTU, 32'd9, 32'd9);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_busy", {63'h0, m.busy}, 64'h0);
    check("rst_mid_hilo", {m.hi, m.lo}, 64'h0);
    repeat (40) step();

    run_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    repeat (3) step();
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
